// File: rtl/svfloat_pkg.sv
// Shared floating-point formats and result classification helpers.
// Contents: float16/float32/float64 packed layouts, flag bit positions,
// exponent-width lookup and a {nan, inf, zero} classifier.
package svfloat;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } float16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
  } float64;

  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned FLAG_NAN  = 2;
  localparam int unsigned FLAG_INF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  // Exponent field width for a format of the given total width.
  function automatic int unsigned exp_width(input int unsigned w);
    case (w)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  // Classify from pre-reduced exponent/mantissa summaries.
  function automatic logic [FLAG_W-1:0] classify(input logic exp_ones,
                                                 input logic exp_zero,
                                                 input logic man_zero);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_NAN]  = exp_ones && !man_zero;
    f[FLAG_INF]  = exp_ones && man_zero;
    f[FLAG_ZERO] = exp_zero && man_zero;
    return f;
  endfunction

endpackage

// File: rtl/svfloat_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data (head,
// combinational from storage), count (0..DEPTH).
// A pop on an empty FIFO is ignored; a push when full is accepted only
// together with a pop.
module svfloat_fifo #(
  parameter type         entry_t = logic [31:0],
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

  // Pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only count marks valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/svfloat_muldiv_ctl.sv
// Issue/collect controller around an external svfloat_muldiv datapath.
// Requests are credited against a result FIFO so no result is ever dropped;
// a LATENCY-deep valid/tag shift register marks when dp_res is valid.
// Ports: clk, rst_n; in_valid/in_ready/in_lhs/in_rhs/in_tag (request);
// dp_lhs/dp_rhs (to datapath), dp_res (from datapath);
// out_valid/out_ready/out_res/out_tag (result); busy.
// Optional macro SVFLOAT_MULDIV_CTL_FLAGS_EN adds out_flags = {nan, inf, zero}
// of the head result, classified at capture and stored per entry.
module svfloat_muldiv_ctl
  import svfloat::*;
#(
  parameter type         float   = svfloat::float32,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  float             in_lhs,
  input  float             in_rhs,
  input  logic [TAG_W-1:0] in_tag,
  output float             dp_lhs,
  output float             dp_rhs,
  input  float             dp_res,
  output logic             out_valid,
  input  logic             out_ready,
  output float             out_res,
  output logic [TAG_W-1:0] out_tag,
`ifdef SVFLOAT_MULDIV_CTL_FLAGS_EN
  output logic [2:0]       out_flags,
`endif
  output logic             busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
`ifdef SVFLOAT_MULDIV_CTL_FLAGS_EN
    logic [2:0]       flags;
`endif
    logic [TAG_W-1:0] tag;
    float             res;
  } entry_t;

  logic             fire;
  logic             pop;
  logic             cap_valid;
  logic [TAG_W-1:0] cap_tag;
  entry_t           cap_entry;
  entry_t           head;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    inflight_nxt;

  assign fire   = in_valid && in_ready;
  assign dp_lhs = in_lhs;
  assign dp_rhs = in_rhs;

  // Valid/tag delay line matching the datapath pipeline depth.
  if (LATENCY == 0) begin : g_lat0
    assign cap_valid = fire;
    assign cap_tag   = in_tag;
  end else begin : g_latn
    logic [LATENCY-1:0] sr_valid;
    logic [TAG_W-1:0]   sr_tag [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_valid <= '0;
        for (int i = 0; i < int'(LATENCY); i++) sr_tag[i] <= '0;
      end else begin
        sr_valid[0] <= fire;
        sr_tag[0]   <= in_tag;
        for (int i = 1; i < int'(LATENCY); i++) begin
          sr_valid[i] <= sr_valid[i-1];
          sr_tag[i]   <= sr_tag[i-1];
        end
      end
    end

    assign cap_valid = sr_valid[LATENCY-1];
    assign cap_tag   = sr_tag[LATENCY-1];
  end

`ifdef SVFLOAT_MULDIV_CTL_FLAGS_EN
  localparam int unsigned FW = $bits(float);
  localparam int unsigned EW = exp_width(FW);
  localparam int unsigned MW = FW - 1 - EW;

  logic [FW-1:0] res_bits;
  assign res_bits = dp_res;
`endif

  // Entry written at the FIFO tail on capture.
  always_comb begin
    cap_entry     = '0;
    cap_entry.res = dp_res;
    cap_entry.tag = cap_tag;
`ifdef SVFLOAT_MULDIV_CTL_FLAGS_EN
    cap_entry.flags = classify(&res_bits[FW-2 -: EW],
                               ~|res_bits[FW-2 -: EW],
                               ~|res_bits[MW-1:0]);
`endif
  end

  svfloat_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cap_valid),
    .push_data (cap_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_res   = head.res;
  assign out_tag   = head.tag;
`ifdef SVFLOAT_MULDIV_CTL_FLAGS_EN
  assign out_flags = head.flags;
`endif
  assign busy      = (inflight != '0) || (count != '0);

  // Next occupancy of the datapath and the FIFO.
  always_comb begin
    inflight_nxt = inflight;
    count_nxt    = count;
    case ({fire, cap_valid})
      2'b10:   inflight_nxt = inflight + CW'(1);
      2'b01:   inflight_nxt = inflight - CW'(1);
      default: inflight_nxt = inflight;
    endcase
    case ({cap_valid, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      in_ready <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      in_ready <= (SW'(inflight_nxt) + SW'(count_nxt)) < SW'(DEPTH);
    end
  end

endmodule
